inject_fifo: RTL
================

// Module: inject_fifo
// PURPOSE
// Per-direction injection buffer between the local compute unit and one router inject port
// (one instance per direction: xpos/ypos/zpos/xneg/yneg/zneg).
// Accepts flits from the local unit with a ready/valid handshake and queues them.
// Drains them into the router only while the router's inject_*_avail is high.
// An optional burst limiter inserts idle cycles so injection cannot monopolise the router crossbar.
// PARAMETERS
// FLIT_W     FLIT_SIZE  flit payload width in bits (FLIT_SIZE from para.sv)
// DEPTH      16         FIFO entries; power of two, >= 2
// MAX_BURST  8          max consecutive pops before one forced idle cycle; 0 = no limit
// PORTS
// clk        in   1                   system clock
// rst        in   1                   reset
// in_flit    in   FLIT_W              flit from local unit
// in_valid   in   1                   in_flit valid
// in_ready   out  1                   buffer can accept this cycle
// out_flit   out  FLIT_W              flit to router inject_* port
// out_valid  out  1                   to router inject_*_valid; 1-cycle pulse per flit
// out_avail  in   1                   from router inject_*_avail; router may take a flit
// count      out  $clog2(DEPTH+1)     current occupancy
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low.
// - Reset: all of the following are cleared at once, not on a clock edge:
//   - count=0, rd/wr pointers=0, out_valid=0, out_flit=0, FSM=SEND, burst counter=0.
// - Reset mid-operation: queued flits are discarded and an in-flight out_valid drops immediately.
// - Push and in_ready:
//   - in_ready = (count != DEPTH), combinational from registered count.
//   - Push occurs when in_valid && in_ready.
//   - in_valid while full is not accepted; upstream must hold the flit.
// - Pop condition at edge t: out_avail && count!=0 && FSM==SEND.
//   - At t+1: out_valid=1 and out_flit = head entry; rd pointer advances.
//   - out_valid is registered; it is 0 in every cycle that does not follow a pop.
//   - out_flit holds its last value when out_valid=0.
// - Count update is cycle-accurate: count_next = count + push - pop.
// - Simultaneous events, count sampled pre-edge:
//   - When full, a same-cycle pop does NOT enable a push (in_ready already 0).
//   - When empty, a same-cycle push cannot pop. Minimum latency from accepted push to out_valid is 2 cycles.
// - Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. Count never exceeds DEPTH or underflows.
// - Burst FSM (active only when MAX_BURST != 0):
//   - SEND: each pop increments burst_cnt.
//     - A pop that makes burst_cnt==MAX_BURST moves to GAP and clears burst_cnt.
//     - Any cycle with no pop (empty or !out_avail) clears burst_cnt.
//   - GAP: no pop for exactly one cycle, then SEND unconditionally.
// - If MAX_BURST==0, the FSM stays in SEND permanently.
// - out_avail deasserting stops pops from the next edge; flits already popped are not recalled.
// CONFIGURATION
// - INJECT_FIFO_STATS_EN defined adds three outputs, all cleared by reset:
//   - drop_attempts  out 16: increments each cycle with in_valid && !in_ready; saturates at 16'hFFFF.
//   - high_water     out $clog2(DEPTH+1): maximum count since reset.
//   - stall_cycles   out 16: increments each cycle with count!=0 && !out_avail; saturates.
// - INJECT_FIFO_STATS_EN undefined: these ports and their logic do not exist.
//   Datapath behaviour is identical in both builds.
// TESTING
// 1. Reset with out_avail=1; push flits 0xA1,0xA2,0xA3 on consecutive cycles.
//    -> out_valid pulses start 2 cycles after the first push, in order A1,A2,A3; count returns to 0.
// 2. out_avail=0; push 16 flits (DEPTH=16).
//    -> count=16, in_ready=0; extra in_valid for 3 cycles leaves count=16.
//    -> (STATS) drop_attempts=3, high_water=16.
// 3. Full FIFO, then out_avail=1 and in_valid=1 together.
//    -> first edge pops only (count=15); push accepted from next edge; no flit lost or duplicated.
// 4. MAX_BURST=8, 20 flits queued, out_avail held 1.
//    -> out_valid pattern: 8 pulses, 1 idle, 8 pulses, 1 idle, 4 pulses.
// 5. Push/pop 40 flits with random out_avail toggling.
//    -> pointers wrap twice; output order equals input order; count matches scoreboard every cycle.
// 6. Assert rst (low) mid-burst with count=5 and out_valid=1.
//    -> out_valid=0 and count=0 without a clock edge; after release, the first new push appears 2 cycles later.

Source files
------------

// File: rtl/inject_fifo.sv
// ---------------------------------------------------------------------------
// inject_fifo
// Per-direction injection buffer between the local compute unit and one
// router inject port. The local unit pushes flits through a ready/valid
// handshake. Flits are drained into the router only while out_avail is high.
// An optional burst limiter forces one idle cycle after MAX_BURST consecutive
// pops, so that injection cannot monopolise the router crossbar.
//
// Parameters
//   FLIT_W     flit payload width in bits
//   DEPTH      FIFO entries (power of two, >= 2)
//   MAX_BURST  max consecutive pops before one forced idle cycle; 0 = no limit
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   in_flit    in   flit from local unit
//   in_valid   in   in_flit valid
//   in_ready   out  buffer can accept this cycle (count != DEPTH)
//   out_flit   out  flit to router inject port (holds when out_valid=0)
//   out_valid  out  one-cycle pulse per flit handed to the router
//   out_avail  in   router may take a flit
//   count      out  current occupancy
//
// Optional build macro INJECT_FIFO_STATS_EN adds:
//   drop_attempts  out 16  cycles with in_valid && !in_ready (saturating)
//   high_water     out     maximum occupancy since reset
//   stall_cycles   out 16  cycles with count != 0 && !out_avail (saturating)
// ---------------------------------------------------------------------------
module inject_fifo #(
  parameter int FLIT_W    = 32,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [FLIT_W-1:0]          in_flit,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [FLIT_W-1:0]          out_flit,
  output logic                       out_valid,
  input  logic                       out_avail,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef INJECT_FIFO_STATS_EN
  ,
  output logic [15:0]                drop_attempts,
  output logic [$clog2(DEPTH+1)-1:0] high_water,
  output logic [15:0]                stall_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST+1);

  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [BW-1:0] BURST_LAST = BW'((MAX_BURST > 0) ? (MAX_BURST - 1) : 0);

  typedef enum logic {
    SEND = 1'b0,
    GAP  = 1'b1
  } state_e;

  logic [FLIT_W-1:0] mem_q [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_flit_q,  out_flit_d;
  state_e            state_q,  state_d;
  logic [BW-1:0]     burst_q,  burst_d;

  logic push;
  logic pop;

  // Both handshakes look only at registered occupancy, so a pop in the same
  // cycle never frees space for a push, and a push into an empty FIFO cannot
  // be popped until the following edge.
  assign in_ready = (count_q != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = out_avail && (count_q != '0) && (state_q == SEND);

  assign count     = count_q;
  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;

  // Storage array carries no reset: entries are only ever read after a push
  // has written them, so their power-up contents never reach out_flit.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_flit;
    end
  end

  // Pointer, occupancy and output register next-state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = pop;
    out_flit_d  = out_flit_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      out_flit_d = mem_q[rd_ptr_q];
    end
  end

  // Burst limiter: count consecutive pops; the pop that reaches MAX_BURST
  // sends us to GAP for exactly one cycle. Any pop-free cycle restarts the
  // count. With MAX_BURST == 0 the limiter is inert and we never leave SEND.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      SEND: begin
        if (MAX_BURST == 0) begin
          burst_d = '0;
        end else if (pop) begin
          if (burst_q == BURST_LAST) begin
            state_d = GAP;
            burst_d = '0;
          end else begin
            burst_d = burst_q + BW'(1);
          end
        end else begin
          burst_d = '0;
        end
      end
      GAP: begin
        state_d = SEND;
        burst_d = '0;
      end
      default: begin
        state_d = SEND;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      state_q     <= SEND;
      burst_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      state_q     <= state_d;
      burst_q     <= burst_d;
    end
  end

`ifdef INJECT_FIFO_STATS_EN
  logic [15:0]   drop_q,  drop_d;
  logic [CW-1:0] hwm_q,   hwm_d;
  logic [15:0]   stall_q, stall_d;

  // Saturating event counters and the occupancy high-water mark. The mark
  // tracks the post-edge count so it agrees with count in the same cycle.
  always_comb begin
    drop_d  = drop_q;
    hwm_d   = hwm_q;
    stall_d = stall_q;
    if (in_valid && !in_ready && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
    if ((count_q != '0) && !out_avail && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
    if (count_d > hwm_q) begin
      hwm_d = count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q  <= '0;
      hwm_q   <= '0;
      stall_q <= '0;
    end else begin
      drop_q  <= drop_d;
      hwm_q   <= hwm_d;
      stall_q <= stall_d;
    end
  end

  assign drop_attempts = drop_q;
  assign high_water    = hwm_q;
  assign stall_cycles  = stall_q;
`endif

endmodule
